// File: rtl/led_fade_pwm_if.sv
// LED fade stage bus: PIO-side requests in, physical LED drive and status out.
interface led_fade_pwm_if #(
  parameter int NUM_LEDS = 8
);
  logic [NUM_LEDS-1:0] led_req;
  logic                enable;
  logic [NUM_LEDS-1:0] led_out;
  logic                busy;

  // Request source (PIO side / bench)
  modport master (output led_req, output enable, input led_out, input busy);
  // Fade engine
  modport slave  (input led_req, input enable, output led_out, output busy);
endinterface

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: per-LED soft fade driven from the PIO out_port.
// Each channel's duty ramps one step per prescaler tick toward 0 or full
// scale and is rendered against a shared free-running PWM counter.
module led_fade_pwm #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int RAMP_DIV = 50000
) (
  input  logic          clk,
  input  logic          reset_n,
  led_fade_pwm_if.slave bus
);

  localparam int                  PRE_W    = $clog2(RAMP_DIV);
  localparam logic [PWM_BITS-1:0] DMAX     = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = DMAX - PWM_BITS'(1);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(RAMP_DIV - 1);

  logic [NUM_LEDS-1:0] r_req_p0;
  logic [NUM_LEDS-1:0] r_req_p1;
  logic [PRE_W-1:0]    r_pre_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_duty [NUM_LEDS];
  logic [NUM_LEDS-1:0] r_led_out;
  logic                r_busy;
  logic                w_tick;
  logic                w_mismatch;

  // One ramp step toward the request, saturating at both ends (never wraps).
  function automatic logic [PWM_BITS-1:0] f_duty_step(input logic [PWM_BITS-1:0] d,
                                                      input logic                up);
    if (up) return (d == DMAX) ? d : d + PWM_BITS'(1);
    else    return (d == '0)   ? d : d - PWM_BITS'(1);
  endfunction

  // ---- stage p0/p1: two-flop resynchroniser of the PIO requests ----
  // Resynchronise led_req; keeps sampling even while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_p0 <= '0;
      r_req_p1 <= '0;
    end else begin
      r_req_p0 <= bus.led_req;
      r_req_p1 <= r_req_p0;
    end
  end

  // Tick is qualified by enable so a frozen prescaler never steps the duty.
  assign w_tick = bus.enable && (r_pre_cnt == PRE_LAST);

  // ---- timebase: ramp prescaler and shared PWM counter ----
  // Advance prescaler (0..RAMP_DIV-1) and PWM counter (0..DMAX-1); both freeze when disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else if (bus.enable) begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
      r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + PWM_BITS'(1);
    end
  end

  // ---- duty: all channels step together on the tick ----
  // Ramp every channel one step toward its synchronised request on each tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LEDS; i++) r_duty[i] <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < NUM_LEDS; i++) r_duty[i] <= f_duty_step(r_duty[i], r_req_p1[i]);
    end
  end

  // Any channel whose duty has not yet reached its target keeps busy high.
  always_comb begin
    w_mismatch = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (r_duty[i] != (r_req_p1[i] ? DMAX : '0)) w_mismatch = 1'b1;
    end
  end

  // ---- output: registered PWM compare and status ----
  // Register the duty-vs-counter compare (blanked by enable) and the busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led_out <= '0;
      r_busy    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) r_led_out[i] <= bus.enable & (r_duty[i] > r_pwm_cnt);
      r_busy <= w_mismatch;
    end
  end

  assign bus.led_out = r_led_out;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm: PWM_BITS=4 (DMAX=15), RAMP_DIV=4.
// A second instance with a slow ramp holds a mid-scale duty long enough to
// inspect whole PWM periods.
module tb_led_fade_pwm;
  localparam int NL   = 8;
  localparam int PB   = 4;
  localparam int RD   = 4;
  localparam int RD_S = 64;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;
  int   cyc_s;

  led_fade_pwm_if #(.NUM_LEDS(NL)) bus ();
  led_fade_pwm_if #(.NUM_LEDS(NL)) bus_s ();

  led_fade_pwm #(.NUM_LEDS(NL), .PWM_BITS(PB), .RAMP_DIV(RD)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  led_fade_pwm #(.NUM_LEDS(NL), .PWM_BITS(PB), .RAMP_DIV(RD_S)) dut_s (
    .clk(clk), .reset_n(reset_n), .bus(bus_s));

  always #5 clk = ~clk;

  // Enabled clock edges of the slow instance since reset; its PWM counter equals this mod 15.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)          cyc_s <= 0;
    else if (bus_s.enable) cyc_s <= cyc_s + 1;
  end

  task automatic do_reset(input logic [7:0] req, input logic [7:0] req_s);
    @(negedge clk);
    reset_n = 1'b0;
    bus.led_req = req;   bus.enable = 1'b1;
    bus_s.led_req = req_s; bus_s.enable = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Waits (sampling on negedges) until the chosen duty equals val; n = cycles taken or -1.
  task automatic wait_duty(input bit slow, input int ch, input int val, input int bound, output int n);
    int d;
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      d = slow ? int'(dut_s.r_duty[ch]) : int'(dut.r_duty[ch]);
      if (d == val) begin n = i; break; end
    end
  endtask

  task automatic test_reset;
    int t, n;
    int bad;
    @(negedge clk);
    reset_n = 1'b0; bus.led_req = 8'hFF; bus.enable = 1'b1;
    bus_s.led_req = 8'h00; bus_s.enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.led_out !== 8'h00) begin errors++; $display("FAIL rst_led_out: got %h expected 00", bus.led_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    reset_n = 1'b1;
    t = 0;
    while (t < 4 && bus.busy !== 1'b1) begin @(negedge clk); t++; end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_busy_rise: got %b expected 1 within 4 cycles", bus.busy); end
    wait_duty(1'b0, 0, 15, 100, n);
    checks++; if (n < 0 || t + n < 56 || t + n > 64) begin errors++; $display("FAIL rst_full_fade: got %0d cycles expected 60+-4", (n < 0) ? -1 : t + n); end
    @(negedge clk);
    bad = 0;
    repeat (30) begin @(negedge clk); if (bus.led_out !== 8'hFF) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_led_full: got %0d off cycles expected 0", bad); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy_fall: got %b expected 0", bus.busy); end
  endtask

  task automatic test_pwm_mid;
    int n, hi, bad;
    logic exp_b;
    do_reset(8'h00, 8'h01);
    wait_duty(1'b1, 0, 5, 600, n);
    checks++; if (n != 320) begin errors++; $display("FAIL mid_reach5: got %0d cycles expected 320", n); end
    hi = 0; bad = 0;
    repeat (15) begin
      @(negedge clk);
      exp_b = (((cyc_s - 1) % 15) < 5);
      if (bus_s.led_out[0]) hi++;
      if (bus_s.led_out[0] !== exp_b) bad++;
    end
    checks++; if (hi != 5) begin errors++; $display("FAIL mid_high_count: got %0d expected 5", hi); end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_phase: got %0d wrong cycles expected 0", bad); end
    bus_s.enable = 1'b0;
    bad = 0;
    repeat (10) begin @(negedge clk); if (bus_s.led_out[0] !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_blank: got %0d lit cycles expected 0", bad); end
    bus_s.enable = 1'b1;
    hi = 0; bad = 0;
    repeat (15) begin
      @(negedge clk);
      exp_b = (((cyc_s - 1) % 15) < 5);
      if (bus_s.led_out[0]) hi++;
      if (bus_s.led_out[0] !== exp_b) bad++;
    end
    checks++; if (hi != 5) begin errors++; $display("FAIL mid_high_count_resume: got %0d expected 5", hi); end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_phase_resume: got %0d wrong cycles expected 0", bad); end
    checks++; if (int'(dut_s.r_duty[0]) != 5) begin errors++; $display("FAIL mid_duty_hold: got %0d expected 5", dut_s.r_duty[0]); end
  endtask

  task automatic test_reversal;
    int n, t, last_t, prev, d, maxd, bad_step, bad_int, bad;
    do_reset(8'h01, 8'h00);
    wait_duty(1'b0, 0, 8, 100, n);
    checks++; if (n != 32) begin errors++; $display("FAIL rev_reach8: got %0d cycles expected 32", n); end
    bus.led_req = 8'h00;
    prev = 8; t = 0; last_t = 0; maxd = 8; bad_step = 0; bad_int = 0;
    while (prev != 0 && t < 100) begin
      @(negedge clk); t++;
      d = int'(dut.r_duty[0]);
      if (d > maxd) maxd = d;
      if (d != prev) begin
        if (d != prev - 1) bad_step++;
        if (t - last_t != 4) bad_int++;
        last_t = t; prev = d;
      end
    end
    checks++; if (t != 32) begin errors++; $display("FAIL rev_down_time: got %0d cycles expected 32", t); end
    checks++; if (bad_step != 0) begin errors++; $display("FAIL rev_step: got %0d bad steps expected 0", bad_step); end
    checks++; if (bad_int != 0) begin errors++; $display("FAIL rev_interval: got %0d bad intervals expected 0", bad_int); end
    checks++; if (maxd != 8) begin errors++; $display("FAIL rev_overshoot: got max %0d expected 8", maxd); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rev_busy_hold: got %b expected 1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rev_busy_fall: got %b expected 0", bus.busy); end
    bad = 0;
    repeat (20) begin @(negedge clk); if (bus.led_out[0] !== 1'b0 || dut.r_duty[0] != 0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL rev_stuck_off: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_saturation;
    int n, bad_d, bad_l;
    do_reset(8'h80, 8'h00);
    wait_duty(1'b0, 7, 15, 100, n);
    checks++; if (n != 60) begin errors++; $display("FAIL sat_reach: got %0d cycles expected 60", n); end
    @(negedge clk);
    bad_d = 0; bad_l = 0;
    repeat (200) begin
      @(negedge clk);
      if (dut.r_duty[7] != 4'd15) bad_d++;
      if (bus.led_out[7] !== 1'b1) bad_l++;
    end
    checks++; if (bad_d != 0) begin errors++; $display("FAIL sat_duty: got %0d bad cycles expected 0", bad_d); end
    checks++; if (bad_l != 0) begin errors++; $display("FAIL sat_led: got %0d dark cycles expected 0", bad_l); end
  endtask

  task automatic test_enable_freeze;
    int n, bad;
    do_reset(8'h01, 8'h00);
    wait_duty(1'b0, 0, 6, 100, n);
    checks++; if (n != 24) begin errors++; $display("FAIL frz_reach6: got %0d cycles expected 24", n); end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++; if (bus.led_out !== 8'h00) begin errors++; $display("FAIL frz_led_next: got %h expected 00", bus.led_out); end
    bad = 0;
    repeat (29) begin @(negedge clk); if (bus.led_out !== 8'h00) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL frz_led_blank: got %0d lit cycles expected 0", bad); end
    checks++; if (dut.r_duty[0] != 4'd6) begin errors++; $display("FAIL frz_duty: got %0d expected 6", dut.r_duty[0]); end
    checks++; if (dut.r_pre_cnt != 0) begin errors++; $display("FAIL frz_pre_cnt: got %0d expected 0", dut.r_pre_cnt); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL frz_busy: got %b expected 1", bus.busy); end
    bus.enable = 1'b1;
    wait_duty(1'b0, 0, 15, 100, n);
    checks++; if (n != 36) begin errors++; $display("FAIL frz_resume: got %0d cycles expected 36", n); end
  endtask

  task automatic test_async_reset;
    int n, bad;
    do_reset(8'h01, 8'h00);
    wait_duty(1'b0, 0, 9, 100, n);
    checks++; if (n != 36) begin errors++; $display("FAIL arst_reach9: got %0d cycles expected 36", n); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.led_out !== 8'h00) begin errors++; $display("FAIL arst_led: got %h expected 00", bus.led_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
    bad = 0;
    for (int i = 0; i < NL; i++) if (dut.r_duty[i] != 0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL arst_duty: got %0d nonzero duties expected 0", bad); end
    @(negedge clk);
    reset_n = 1'b1;
    wait_duty(1'b0, 0, 1, 20, n);
    checks++; if (n != 4) begin errors++; $display("FAIL arst_restart: got %0d cycles expected 4", n); end
  endtask

  initial begin
    bus.led_req = '0;   bus.enable = 1'b1;
    bus_s.led_req = '0; bus_s.enable = 1'b1;
    test_reset();
    test_pwm_mid();
    test_reversal();
    test_saturation();
    test_enable_freeze();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
